decode_ctrl: RTL and testbench
==============================

DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 Parameter FETCH_WIDTH, default 4: instructions per fetch group.
REQ-002 Parameter DECODE_WIDTH, default 4: decode slots driven per cycle, each slot feeding one decode unit.
REQ-003 Parameter IBUF_DEPTH, default 16: instruction buffer entries, power of two, at least FETCH_WIDTH+DECODE_WIDTH.
REQ-004 clk  in  1  sole clock; all state on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 fetch_valid  in  1  a fetch group is offered.
REQ-007 fetch_ready  out  1  the controller accepts the group this cycle.
REQ-008 fetch_mask  in  FETCH_WIDTH  per-slot valid bits, contiguous from slot 0.
REQ-009 fetch_inst  in  FETCH_WIDTH*32  raw instruction words.
REQ-010 fetch_pc  in  FETCH_WIDTH*XLEN  PC of each slot.
REQ-011 dec_valid  out  DECODE_WIDTH  per-slot valid bits, contiguous from slot 0.
REQ-012 dec_inst  out  DECODE_WIDTH*32  instruction words to the decode units.
REQ-013 dec_pc  out  DECODE_WIDTH*XLEN  PCs matching dec_inst.
REQ-014 dec_ready  in  1  the downstream (rename) stage consumes the current output group.
REQ-015 redirect  in  1  flush from backend or branch mispredict.
REQ-016 csr_done  in  1  the serialized SYSTEM instruction has retired; ignored unless DECODE_CSR_SERIAL_EN is defined.

Function
REQ-017 Buffer: circular, IBUF_DEPTH entries; head and tail pointers carry a wrap bit; full/empty are distinguished by that wrap bit.
REQ-018 fetch_ready is 1 iff free entries >= FETCH_WIDTH, computed from registered state only, with no credit for a same-cycle dequeue.
REQ-019 Enqueue occurs on fetch_valid&fetch_ready and writes popcount(fetch_mask) entries in slot order; tail advances modulo IBUF_DEPTH with wrap.
REQ-020 Output register: loaded when it is empty or dec_ready=1, with n=min(count, DECODE_WIDTH, serial limit) oldest entries; head advances by n.
REQ-021 Output register: holds its value unchanged while dec_valid!=0 and dec_ready=0.
REQ-022 Latency: an entry enqueued in cycle N is presented on dec_* no earlier than cycle N+1.
REQ-023 Ordering: program order is preserved across slots and groups.
REQ-024 Simultaneous enqueue and dequeue in one cycle are both performed.
REQ-025 Empty buffer with dec_ready=1: dec_valid becomes 0 next cycle.
REQ-026 redirect: takes priority over enqueue, dequeue and csr_done.
REQ-027 redirect: next cycle head=tail=0, wrap bits=0, dec_valid=0, state=RUN; a fetch group offered in the redirect cycle is dropped.
REQ-028 State machine: states RUN and WAIT; WAIT exists only with DECODE_CSR_SERIAL_EN.

Reset
REQ-029 On rst: head=tail=0, wrap bits=0, dec_valid=0, dec_inst=0, dec_pc=0, state=RUN; fetch_ready=1 in the first cycle after rst deasserts.
REQ-030 rst asserted mid-operation discards all buffered and output entries immediately and asynchronously.

Configuration
REQ-031 Macro DECODE_CSR_SERIAL_EN selects CSR serialization. A SYSTEM instruction has inst[6:2]=11100 and inst[1:0]=11.
REQ-032 With DECODE_CSR_SERIAL_EN, SYSTEM at window position k>0: only entries 0..k-1 are loaded.
REQ-033 With DECODE_CSR_SERIAL_EN, SYSTEM at position 0: it is loaded alone, state goes to WAIT, and no further loads occur until csr_done=1 returns state to RUN (load resumes the cycle after).
REQ-034 With DECODE_CSR_SERIAL_EN, enqueue continues normally in WAIT.
REQ-035 Without DECODE_CSR_SERIAL_EN: SYSTEM is treated as any other instruction, state is always RUN, and csr_done is unused.

Structure
REQ-036 Shared package holds FETCH_WIDTH, DECODE_WIDTH and IBUF_DEPTH defaults, the ibuf entry typedef {inst[31:0], pc[XLEN-1:0]}, and the state enum {RUN, WAIT}.
REQ-037 Sub-module decode_ibuf: circular storage, pointers and free count. decode_ctrl owns the output register, serialization FSM and redirect handling.

Verification
REQ-038 Stream: 4 full groups (mask 1111), dec_ready=1 constantly -> 16 instructions out in order, 4 per cycle, first at cycle 1 after first accept.
REQ-039 Backpressure: dec_ready=0 for 10 cycles with fetch_valid=1 -> fetch_ready drops once 13 entries are used; dec_* stays stable; nothing is lost or duplicated after release.
REQ-040 Wrap: masks 0111 repeated 12 times with dec_ready toggling -> pointer wraps past entry 15 and order is preserved.
REQ-041 Redirect while full with fetch_valid=1 -> next cycle dec_valid=0, fetch_ready=1, the dropped group never appears.
REQ-042 DECODE_CSR_SERIAL_EN, group {addi, csrrw, add, lw} -> cycle A outputs addi only; cycle B outputs csrrw only; add and lw appear only the cycle after csr_done=1.
REQ-043 rst pulsed mid-stream with 9 entries buffered -> all outputs zero immediately; after release, first new group out with no stale data.

Source files
------------

// File: rtl/decode_ctrl_pkg.sv
// decode_ctrl_pkg: shared types and defaults for the decode controller.
//   XLEN                     : PC width
//   *_DEF                    : default fetch/decode widths and buffer depth
//   ibuf_entry_t             : one buffered instruction {inst, pc}
//   state_t                  : serialization FSM states (WAIT used only with
//                              DECODE_CSR_SERIAL_EN)
//   is_system()              : SYSTEM opcode detect (inst[6:0] == 1110011)
package decode_ctrl_pkg;
  localparam int XLEN             = 32;
  localparam int FETCH_WIDTH_DEF  = 4;
  localparam int DECODE_WIDTH_DEF = 4;
  localparam int IBUF_DEPTH_DEF   = 16;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } ibuf_entry_t;

  typedef enum logic {RUN, WAIT} state_t;

  function automatic logic is_system(input logic [6:0] opc);
    return opc == 7'b1110011;
  endfunction
endpackage

// File: rtl/decode_ctrl_if.sv
// Handshake bundles for the decode controller.
//   fetch_if : fetch group into the controller (master = fetch unit,
//              slave = controller). fetch_mask is contiguous from slot 0.
//   dec_if   : decode group out of the controller (master = controller,
//              slave = rename). dec_valid is contiguous from slot 0.
interface fetch_if import decode_ctrl_pkg::*; #(
  parameter int W = FETCH_WIDTH_DEF
);
  logic                     fetch_valid;
  logic                     fetch_ready;
  logic [W-1:0]             fetch_mask;
  logic [W-1:0][31:0]       fetch_inst;
  logic [W-1:0][XLEN-1:0]   fetch_pc;

  modport master (output fetch_valid, fetch_mask, fetch_inst, fetch_pc,
                  input  fetch_ready);
  modport slave  (input  fetch_valid, fetch_mask, fetch_inst, fetch_pc,
                  output fetch_ready);
endinterface

interface dec_if import decode_ctrl_pkg::*; #(
  parameter int W = DECODE_WIDTH_DEF
);
  logic [W-1:0]             dec_valid;
  logic [W-1:0][31:0]       dec_inst;
  logic [W-1:0][XLEN-1:0]   dec_pc;
  logic                     dec_ready;

  modport master (output dec_valid, dec_inst, dec_pc, input  dec_ready);
  modport slave  (input  dec_valid, dec_inst, dec_pc, output dec_ready);
endinterface

// File: rtl/decode_ctrl_ibuf.sv
// decode_ibuf: circular instruction buffer.
//   clk, rst      : clock, async active-high reset (pointers only)
//   flush         : zero both pointers next cycle (wins over enq/deq)
//   enq, enq_mask : write popcount(enq_mask) entries at tail, slot order
//   enq_data      : entries for each fetch slot
//   deq_n         : entries retired from head this cycle
//   count, free   : occupancy from registered pointers
//   rd_data       : the DECODE_WIDTH oldest entries starting at head
// Pointers carry an extra wrap bit so count == DEPTH is distinct from 0.
module decode_ibuf import decode_ctrl_pkg::*; #(
  parameter  int FETCH_WIDTH  = FETCH_WIDTH_DEF,
  parameter  int DECODE_WIDTH = DECODE_WIDTH_DEF,
  parameter  int IBUF_DEPTH   = IBUF_DEPTH_DEF,
  localparam int AW           = $clog2(IBUF_DEPTH),
  localparam int CW           = AW + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           enq,
  input  logic [FETCH_WIDTH-1:0]         enq_mask,
  input  ibuf_entry_t [FETCH_WIDTH-1:0]  enq_data,
  input  logic [CW-1:0]                  deq_n,
  output logic [CW-1:0]                  count,
  output logic [CW-1:0]                  free,
  output ibuf_entry_t [DECODE_WIDTH-1:0] rd_data
);
  logic [CW-1:0] head_q, head_d, tail_q, tail_d, enq_cnt;
  ibuf_entry_t   mem_q [IBUF_DEPTH];

  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) enq_cnt = enq_cnt + CW'(enq_mask[i]);
  end

  always_comb begin
    head_d = head_q + deq_n;
    tail_d = enq ? tail_q + enq_cnt : tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Mask is contiguous, so slot i always lands at tail+i.
  always_ff @(posedge clk) begin
    if (enq && !flush)
      for (int i = 0; i < FETCH_WIDTH; i++)
        if (enq_mask[i]) mem_q[tail_q[AW-1:0] + AW'(i)] <= enq_data[i];
  end

  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++)
      rd_data[i] = mem_q[head_q[AW-1:0] + AW'(i)];
  end

  assign count = tail_q - head_q;
  assign free  = CW'(IBUF_DEPTH) - count;
endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: instruction buffer + decode output register.
//   clk, rst  : clock, async active-high reset
//   fif       : fetch group in (fetch_valid/ready, mask, inst, pc)
//   dif       : decode group out (dec_valid, inst, pc, dec_ready)
//   redirect  : flush buffer and output register; drops same-cycle fetch
//   csr_done  : serialized SYSTEM retired (used only with the macro below)
// Build option: DECODE_CSR_SERIAL_EN - a SYSTEM instruction ends the decode
// group before it; at slot 0 it goes out alone and loading stalls in WAIT
// until csr_done.
module decode_ctrl import decode_ctrl_pkg::*; #(
  parameter int FETCH_WIDTH  = FETCH_WIDTH_DEF,
  parameter int DECODE_WIDTH = DECODE_WIDTH_DEF,
  parameter int IBUF_DEPTH   = IBUF_DEPTH_DEF
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.slave   fif,
  dec_if.master    dif,
  input  logic     redirect,
  input  logic     csr_done
);
  localparam int CW = $clog2(IBUF_DEPTH) + 1;

  logic [CW-1:0] count, free, avail, n, deq_n;
  logic          enq, load_en;
  ibuf_entry_t [FETCH_WIDTH-1:0]  enq_data;
  ibuf_entry_t [DECODE_WIDTH-1:0] rd_data;

  logic [DECODE_WIDTH-1:0]            dec_valid_q, dec_valid_d;
  logic [DECODE_WIDTH-1:0][31:0]      dec_inst_q, dec_inst_d;
  logic [DECODE_WIDTH-1:0][XLEN-1:0]  dec_pc_q, dec_pc_d;

  // Ready looks only at registered occupancy; no credit for this cycle's dequeue.
  assign fif.fetch_ready = free >= CW'(FETCH_WIDTH);
  assign enq             = fif.fetch_valid & fif.fetch_ready & ~redirect;

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++)
      enq_data[i] = '{inst: fif.fetch_inst[i], pc: fif.fetch_pc[i]};
  end

  decode_ibuf #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .DECODE_WIDTH(DECODE_WIDTH),
    .IBUF_DEPTH  (IBUF_DEPTH)
  ) u_ibuf (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .enq     (enq),
    .enq_mask(fif.fetch_mask),
    .enq_data(enq_data),
    .deq_n   (deq_n),
    .count   (count),
    .free    (free),
    .rd_data (rd_data)
  );

  assign avail   = (count > CW'(DECODE_WIDTH)) ? CW'(DECODE_WIDTH) : count;
  assign load_en = (dec_valid_q == '0) || dif.dec_ready;

`ifdef DECODE_CSR_SERIAL_EN
  state_t state_q, state_d;
  logic   sys_found;

  // Cut the window at the first SYSTEM; a SYSTEM at slot 0 goes alone and
  // parks the FSM in WAIT, where nothing loads until csr_done is seen.
  always_comb begin
    state_d   = state_q;
    n         = avail;
    sys_found = 1'b0;
    if (redirect) begin
      state_d = RUN;
    end else if (state_q == WAIT) begin
      n = '0;
      if (csr_done) state_d = RUN;
    end else begin
      for (int i = 0; i < DECODE_WIDTH; i++) begin
        if (!sys_found && CW'(i) < avail && is_system(rd_data[i].inst[6:0])) begin
          sys_found = 1'b1;
          n         = (i == 0) ? CW'(1) : CW'(i);
          if (i == 0 && load_en) state_d = WAIT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end
`else
  logic csr_done_unused;
  assign csr_done_unused = csr_done;
  assign n               = avail;
`endif

  // Output register: reload when empty or consumed, otherwise hold.
  // Unused slots are zeroed so stale words never leak onto dec_inst/dec_pc.
  always_comb begin
    deq_n       = '0;
    dec_valid_d = dec_valid_q;
    dec_inst_d  = dec_inst_q;
    dec_pc_d    = dec_pc_q;
    if (redirect) begin
      dec_valid_d = '0;
      dec_inst_d  = '0;
      dec_pc_d    = '0;
    end else if (load_en) begin
      deq_n = n;
      for (int i = 0; i < DECODE_WIDTH; i++) begin
        dec_valid_d[i] = CW'(i) < n;
        dec_inst_d[i]  = dec_valid_d[i] ? rd_data[i].inst : '0;
        dec_pc_d[i]    = dec_valid_d[i] ? rd_data[i].pc   : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_valid_q <= '0;
      dec_inst_q  <= '0;
      dec_pc_q    <= '0;
    end else begin
      dec_valid_q <= dec_valid_d;
      dec_inst_q  <= dec_inst_d;
      dec_pc_q    <= dec_pc_d;
    end
  end

  assign dif.dec_valid = dec_valid_q;
  assign dif.dec_inst  = dec_inst_q;
  assign dif.dec_pc    = dec_pc_q;
endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: directed bench for decode_ctrl with an in-order scoreboard
// and a small occupancy model for fetch_ready / dec_valid.
module tb_decode_ctrl;
  import decode_ctrl_pkg::*;
  localparam int FW = 4, DW = 4, DEPTH = 16;

  logic clk = 1'b0, rst, redirect, csr_done;
  always #5 clk = ~clk;

  fetch_if #(.W(FW)) fif();
  dec_if   #(.W(DW)) dif();

  decode_ctrl #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .IBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fif(fif), .dif(dif),
    .redirect(redirect), .csr_done(csr_done)
  );

  ibuf_entry_t exp_q[$];
  int checks = 0, passes = 0;
  int cnt = 0, ocnt = 0, tag = 0, acc_groups = 0;
  bit model_on = 1'b1;
  logic [DW-1:0]           hold_v;
  logic [DW-1:0][31:0]     hold_i;
  logic [DW-1:0][XLEN-1:0] hold_p;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [31:0] mk_inst(input int t);
    logic [11:0] t12;
    t12 = t[11:0];
    return {t12, 13'h0, 7'b0010011};
  endfunction

  task automatic fill(input logic [FW-1:0] m);
    fif.fetch_mask = m;
    for (int i = 0; i < FW; i++) begin
      fif.fetch_inst[i] = mk_inst(tag + i);
      fif.fetch_pc[i]   = 32'h1000 + 32'(4 * (tag + i));
    end
  endtask

  // Called just after a negedge with inputs applied: score the edge ahead.
  task automatic tick();
    ibuf_entry_t e;
    int nl;
    logic acc;
    #1;
    if (model_on) begin
      chk("fetch_ready", fif.fetch_ready, 64'((DEPTH - cnt) >= FW));
      chk("dec_valid", dif.dec_valid, 64'((1 << ocnt) - 1));
    end
    if (dif.dec_ready && !redirect) begin
      for (int i = 0; i < DW; i++) begin
        if (dif.dec_valid[i]) begin
          checks++;
          assert (exp_q.size() != 0) passes++;
          else $error("FAIL unexpected_out: got slot%0d inst %0h expected none", i, dif.dec_inst[i]);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_inst", dif.dec_inst[i], e.inst);
            chk("out_pc", dif.dec_pc[i], e.pc);
          end
        end
      end
    end
    acc = fif.fetch_valid && fif.fetch_ready && !redirect;
    if (redirect) begin
      cnt = 0; ocnt = 0; exp_q.delete();
    end else begin
      if (ocnt == 0 || dif.dec_ready) begin
        nl = (cnt < DW) ? cnt : DW;
        ocnt = nl; cnt -= nl;
      end
      if (acc) begin
        for (int i = 0; i < FW; i++)
          if (fif.fetch_mask[i]) exp_q.push_back('{inst: fif.fetch_inst[i], pc: fif.fetch_pc[i]});
        cnt += $countones(fif.fetch_mask);
        tag += $countones(fif.fetch_mask);
        acc_groups++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    fif.fetch_valid = 1'b0;
    dif.dec_ready   = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] prog [4];
    prog = '{32'h00100093, 32'h30009073, 32'h002081B3, 32'h0000A203};
    rst = 1'b1; redirect = 1'b0; csr_done = 1'b0;
    fif.fetch_valid = 1'b0; dif.dec_ready = 1'b0;
    fill('0);
    #1;
    chk("rst_dec_valid", dif.dec_valid, 0);
    chk("rst_dec_inst", 64'(|dif.dec_inst), 0);
    chk("rst_dec_pc", 64'(|dif.dec_pc), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_ready", fif.fetch_ready, 1);

    // Stream: four full groups, consumer always ready.
    dif.dec_ready = 1'b1; fif.fetch_valid = 1'b1; acc_groups = 0;
    for (int k = 0; k < 4; k++) begin fill(4'hF); tick(); end
    chk("stream_groups", acc_groups, 4);
    drain();

    // Backpressure: ready drops at 13 buffered; outputs hold.
    dif.dec_ready = 1'b0; fif.fetch_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      fill(k == 4 ? 4'h1 : 4'hF);
      tick();
      if (k == 1) begin hold_v = dif.dec_valid; hold_i = dif.dec_inst; hold_p = dif.dec_pc; end
      if (k == 4) chk("bp_ready_low", fif.fetch_ready, 0);
      if (k >= 2) begin
        chk("bp_hold_valid", dif.dec_valid, hold_v);
        chk("bp_hold_inst", dif.dec_inst[0], hold_i[0]);
        chk("bp_hold_pc", dif.dec_pc[DW-1], hold_p[DW-1]);
      end
    end
    drain();

    // Wrap: twelve 3-wide groups with toggling consumer.
    acc_groups = 0; fif.fetch_valid = 1'b1;
    for (int k = 0; k < 80 && acc_groups < 12; k++) begin
      dif.dec_ready = k[0];
      fill(4'h7);
      tick();
    end
    chk("wrap_groups", acc_groups, 12);
    drain();

    // Redirect while full, with a group offered in the same cycle.
    dif.dec_ready = 1'b0; fif.fetch_valid = 1'b1;
    for (int k = 0; k < 12 && fif.fetch_ready; k++) begin fill(4'hF); tick(); end
    chk("full_ready_low", fif.fetch_ready, 0);
    fill(4'hF); redirect = 1'b1;
    tick();
    redirect = 1'b0; fif.fetch_valid = 1'b0;
    chk("redir_dec_valid", dif.dec_valid, 0);
    chk("redir_ready", fif.fetch_ready, 1);
    dif.dec_ready = 1'b1;
    repeat (3) tick();
    chk("redir_no_ghost", exp_q.size(), 0);

    // Async reset with 9 entries held (4 in output, 5 buffered).
    dif.dec_ready = 1'b0; fif.fetch_valid = 1'b1;
    fill(4'hF); tick(); fill(4'hF); tick(); fill(4'h1); tick();
    fif.fetch_valid = 1'b0;
    chk("pre_rst_valid", dif.dec_valid, 4'hF);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", dif.dec_valid, 0);
    chk("mid_rst_inst", 64'(|dif.dec_inst), 0);
    chk("mid_rst_pc", 64'(|dif.dec_pc), 0);
    chk("mid_rst_ready", fif.fetch_ready, 1);
    cnt = 0; ocnt = 0; exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    dif.dec_ready = 1'b1; fif.fetch_valid = 1'b1;
    fill(4'hF); tick();
    drain();

    // SYSTEM group {addi, csrrw, add, lw}.
    fif.fetch_valid = 1'b1; fif.fetch_mask = 4'hF; dif.dec_ready = 1'b1;
    for (int i = 0; i < FW; i++) begin
      fif.fetch_inst[i] = prog[i];
      fif.fetch_pc[i]   = 32'h2000 + 32'(4 * i);
    end
`ifdef DECODE_CSR_SERIAL_EN
    model_on = 1'b0;
    tick(); fif.fetch_valid = 1'b0;
    tick();
    chk("csr_a_valid", dif.dec_valid, 4'h1);
    chk("csr_a_inst", dif.dec_inst[0], prog[0]);
    tick();
    chk("csr_b_valid", dif.dec_valid, 4'h1);
    chk("csr_b_inst", dif.dec_inst[0], prog[1]);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("csr_wait_valid", dif.dec_valid, 0);
    end
    csr_done = 1'b1; tick(); csr_done = 1'b0;
    chk("csr_done_cycle", dif.dec_valid, 0);
    tick();
    chk("csr_resume_valid", dif.dec_valid, 4'h3);
    chk("csr_resume_inst", dif.dec_inst[1], prog[3]);
`else
    tick(); fif.fetch_valid = 1'b0;
    tick();
    chk("sys_plain_valid", dif.dec_valid, 4'hF);
    chk("sys_plain_inst", dif.dec_inst[1], prog[1]);
`endif
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
